calc_opcode_deserializer: RTL and testbench



---
 rtl/calc_opcode_deserializer_if.sv | 31 +++
 rtl/calc_opcode_deserializer.sv | 149 ++++++++++++++
 tb/tb_calc_opcode_deserializer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/calc_opcode_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_opcode_deserializer_if
// Purpose  : Serial bit stream in, committed opcode out, plus status.
// Revision : 1.0
// ============================================================================
interface calc_opcode_deserializer_if #(
  parameter int WIDTH = 14
);
  logic             bit_in;
  logic             bit_valid;
  logic             frame_start;
  logic             bit_ready;
  logic [WIDTH-1:0] opcode;
  logic             opcode_valid;
  logic             opcode_ready;
  logic             parity_err;
  logic             timeout_err;
  logic [7:0]       frame_count;

  modport master (
    output bit_in, bit_valid, frame_start, opcode_ready,
    input  bit_ready, opcode, opcode_valid, parity_err, timeout_err, frame_count
  );

  modport slave (
    input  bit_in, bit_valid, frame_start, opcode_ready,
    output bit_ready, opcode, opcode_valid, parity_err, timeout_err, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/calc_opcode_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : calc_opcode_deserializer
// Purpose  : MSB-first serial-to-opcode assembler with odd parity and timeout.
// Revision : 1.0
// ============================================================================
module calc_opcode_deserializer #(
  parameter int WIDTH     = 14,
  parameter int TIMEOUT   = 16,
  parameter int PARITY_EN = 1
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  calc_opcode_deserializer_if.slave  bus
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);
  localparam int c_TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SHIFT  = 2'd1;
  localparam logic [1:0] c_PARITY = 2'd2;
  localparam logic [1:0] c_HOLD   = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_TO_W-1:0]  r_idle;
  logic [WIDTH-1:0]   r_opcode;
  logic               r_opcode_valid;
  logic               r_parity_err;
  logic               r_timeout_err;
  logic [7:0]         r_frame_count;

  logic               w_bit_ready;
  logic               w_accept;
  logic               w_restart;
  logic               w_in_frame;
  logic               w_last_bit;
  logic               w_par_ok;
  logic               w_timeout;
  logic               w_commit;
  logic               w_par_bad;
  logic               w_handshake;
  logic [WIDTH-1:0]   w_shifted;

  assign w_accept    = bus.bit_valid && w_bit_ready;
  assign w_restart   = w_accept && bus.frame_start;
  assign w_in_frame  = (r_state == c_SHIFT) || (r_state == c_PARITY);
  assign w_last_bit  = (r_cnt == c_CNT_W'(WIDTH - 1));
  assign w_shifted   = {r_shreg[WIDTH-2:0], bus.bit_in};
  assign w_par_ok    = (^r_shreg) ^ bus.bit_in;
  // A bit arriving on the would-be timeout cycle wins over the timeout.
  assign w_timeout   = w_in_frame && !w_accept && (r_idle == c_TO_W'(TIMEOUT - 1));
  assign w_handshake = (r_state == c_HOLD) && bus.opcode_ready;
  assign w_par_bad   = (r_state == c_PARITY) && w_accept && !bus.frame_start && !w_par_ok;
  assign w_commit    = ((r_state == c_SHIFT) && w_accept && !bus.frame_start && w_last_bit
                        && (PARITY_EN == 0))
                    || ((r_state == c_PARITY) && w_accept && !bus.frame_start && w_par_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_restart) w_next_state = c_SHIFT;
      end
      c_SHIFT: begin
        if (w_restart)                   w_next_state = c_SHIFT;
        else if (w_commit)               w_next_state = c_HOLD;
        else if (w_accept && w_last_bit) w_next_state = c_PARITY;
        else if (w_timeout)              w_next_state = c_IDLE;
      end
      c_PARITY: begin
        if (w_restart)      w_next_state = c_SHIFT;
        else if (w_commit)  w_next_state = c_HOLD;
        else if (w_par_bad) w_next_state = c_IDLE;
        else if (w_timeout) w_next_state = c_IDLE;
      end
      c_HOLD: begin
        if (w_handshake) w_next_state = c_IDLE;
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_bit_ready = (r_state != c_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg        <= '0;
      r_cnt          <= '0;
      r_idle         <= '0;
      r_opcode       <= '0;
      r_opcode_valid <= 1'b0;
      r_parity_err   <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_frame_count  <= '0;
    end else begin
      if (w_restart) begin
        r_shreg <= {{(WIDTH-1){1'b0}}, bus.bit_in};
        r_cnt   <= c_CNT_W'(1);
      end else if ((r_state == c_SHIFT) && w_accept) begin
        r_shreg <= w_shifted;
        r_cnt   <= r_cnt + c_CNT_W'(1);
      end

      if (w_in_frame && !w_accept && !w_timeout) begin
        r_idle <= r_idle + c_TO_W'(1);
      end else begin
        r_idle <= '0;
      end

      // Without a parity bit the last data bit is still in flight on commit.
      if (w_commit) begin
        r_opcode       <= (r_state == c_PARITY) ? r_shreg : w_shifted;
        r_opcode_valid <= 1'b1;
      end else if (w_handshake) begin
        r_opcode_valid <= 1'b0;
      end

      if (w_handshake) begin
        r_frame_count <= r_frame_count + 8'd1;
      end

      r_parity_err  <= w_par_bad;
      r_timeout_err <= w_timeout;
    end
  end

  assign bus.bit_ready    = w_bit_ready;
  assign bus.opcode       = r_opcode;
  assign bus.opcode_valid = r_opcode_valid;
  assign bus.parity_err   = r_parity_err;
  assign bus.timeout_err  = r_timeout_err;
  assign bus.frame_count  = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_calc_opcode_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_opcode_deserializer
// Purpose  : Directed self-checking bench with an opcode scoreboard.
// Revision : 1.0
// ============================================================================
module tb_calc_opcode_deserializer;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;
  int   n_perr;
  int   n_terr;
  logic [13:0] sb_q[$];

  calc_opcode_deserializer_if #(.WIDTH(14)) bus ();

  calc_opcode_deserializer #(
    .WIDTH     (14),
    .TIMEOUT   (16),
    .PARITY_EN (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic good_par(input logic [13:0] d);
    return ~(^d);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; a handshake seen before the edge is scored against the queue.
  task automatic tick();
    logic [13:0] exp_op;
    if (bus.opcode_valid === 1'b1 && bus.opcode_ready === 1'b1) begin
      check("sb_pending", {31'd0, sb_q.size() > 0}, 32'd1);
      if (sb_q.size() > 0) begin
        exp_op = sb_q.pop_front();
        check("sb_opcode", {18'd0, bus.opcode}, {18'd0, exp_op});
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (bus.parity_err === 1'b1) n_perr++;
    if (bus.timeout_err === 1'b1) n_terr++;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    bus.bit_in      = b;
    bus.frame_start = fs;
    bus.bit_valid   = 1'b1;
    tick();
  endtask

  task automatic send_frame(input logic [13:0] d, input logic p, input bit push);
    if (push) sb_q.push_back(d);
    for (int i = 13; i >= 0; i--) send_bit(d[i], i == 13);
    send_bit(p, 1'b0);
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  initial begin
    logic [13:0] d;
    logic        early;
    n_vec = 0; n_miss = 0; n_perr = 0; n_terr = 0;
    rst_n = 1'b0;
    bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.frame_start = 1'b0; bus.opcode_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_opcode", {18'd0, bus.opcode}, 32'd0);
    check("rst_valid", {31'd0, bus.opcode_valid}, 32'd0);
    check("rst_fc", {24'd0, bus.frame_count}, 32'd0);
    check("rst_ready", {31'd0, bus.bit_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Basic frame; valid rises right after the parity edge, for one cycle.
    send_frame(14'b01010000100000, 1'b0, 1'b1);
    check("f1_valid_rise", {31'd0, bus.opcode_valid}, 32'd1);
    check("f1_opcode", {18'd0, bus.opcode}, 32'h1420);
    tick();
    check("f1_valid_fall", {31'd0, bus.opcode_valid}, 32'd0);
    check("f1_fc", {24'd0, bus.frame_count}, 32'd1);

    // Bad parity, then the corrected resend.
    send_frame(14'b10101001010000, 1'b1, 1'b0);
    check("perr_pulse", {31'd0, bus.parity_err}, 32'd1);
    check("perr_valid", {31'd0, bus.opcode_valid}, 32'd0);
    tick();
    check("perr_clear", {31'd0, bus.parity_err}, 32'd0);
    check("perr_count", n_perr, 32'd1);
    check("perr_opcode", {18'd0, bus.opcode}, 32'h1420);
    send_frame(14'b10101001010000, good_par(14'h2A50), 1'b1);
    check("f2_opcode", {18'd0, bus.opcode}, 32'h2A50);
    tick();

    // Consumer stalls five cycles while upstream keeps pushing bits.
    bus.opcode_ready = 1'b0;
    send_frame(14'b11001000000000, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", {31'd0, bus.opcode_valid}, 32'd1);
      check("hold_ready", {31'd0, bus.bit_ready}, 32'd0);
      check("hold_opcode", {18'd0, bus.opcode}, 32'h3200);
      bus.bit_valid = 1'b1; bus.frame_start = 1'b1; bus.bit_in = 1'($urandom);
      tick();
    end
    bus.bit_valid = 1'b0; bus.frame_start = 1'b0;
    check("hold_fc_before", {24'd0, bus.frame_count}, 32'd2);
    bus.opcode_ready = 1'b1;
    tick();
    check("hold_fc_after", {24'd0, bus.frame_count}, 32'd3);
    check("hold_retained", {18'd0, bus.opcode}, 32'h3200);
    check("hold_state_idle", {31'd0, bus.bit_ready}, 32'd1);

    // Stalled frame: seven bits then silence.
    for (int i = 0; i < 7; i++) send_bit(1'b1, i == 0);
    bus.bit_valid = 1'b0;
    early = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      early |= bus.timeout_err;
    end
    check("to_not_early", {31'd0, early}, 32'd0);
    tick();
    check("to_pulse", {31'd0, bus.timeout_err}, 32'd1);
    tick();
    check("to_clear", {31'd0, bus.timeout_err}, 32'd0);
    check("to_count", n_terr, 32'd1);
    check("to_opcode", {18'd0, bus.opcode}, 32'h3200);
    send_frame(14'h0ABC, good_par(14'h0ABC), 1'b1);
    tick();
    check("to_fc", {24'd0, bus.frame_count}, 32'd4);

    // Resync after nine bits.
    for (int i = 0; i < 9; i++) send_bit(1'b1, i == 0);
    send_frame(14'b00000000000001, 1'b0, 1'b1);
    check("resync_opcode", {18'd0, bus.opcode}, 32'h0001);
    tick();
    check("resync_perr", n_perr, 32'd1);
    check("resync_terr", n_terr, 32'd1);

    // Asynchronous reset mid-frame, between clock edges.
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    bus.bit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_opcode", {18'd0, bus.opcode}, 32'd0);
    check("arst_valid", {31'd0, bus.opcode_valid}, 32'd0);
    check("arst_fc", {24'd0, bus.frame_count}, 32'd0);
    check("arst_errs", {30'd0, bus.parity_err, bus.timeout_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_frame(14'h2A50, good_par(14'h2A50), 1'b1);
    check("post_rst_opcode", {18'd0, bus.opcode}, 32'h2A50);
    tick();
    check("post_rst_fc", {24'd0, bus.frame_count}, 32'd1);

    // Wrap the frame counter.
    for (int f = 0; f < 254; f++) begin
      d = 14'($urandom);
      send_frame(d, good_par(d), 1'b1);
      tick();
    end
    check("fc_255", {24'd0, bus.frame_count}, 32'd255);
    d = 14'($urandom);
    send_frame(d, good_par(d), 1'b1);
    tick();
    check("fc_wrap", {24'd0, bus.frame_count}, 32'd0);
    check("sb_drained", sb_q.size(), 32'd0);
    check("no_stray_errs", n_perr + n_terr, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
